// File: rtl/uart_tx_feeder_pkg.sv
// Shared definitions for the uart_tx feeder: downstream uart_tx offsets,
// feeder register map and the master-side FSM encoding.
package uart_tx_feeder_pkg;

  localparam logic [31:0] TX_DATA_OFS = 32'h0000_0000;
  localparam logic [31:0] TX_CTRL_OFS = 32'h0000_000c;
  localparam int          TX_BUSY_BIT = 12;

  localparam logic [31:0] REG_DATA = 32'h0000_0000;
  localparam logic [31:0] REG_STAT = 32'h0000_0004;
  localparam logic [31:0] REG_CTRL = 32'h0000_0008;

  localparam int STAT_EMPTY = 8;
  localparam int STAT_FULL  = 9;
  localparam int STAT_OVF   = 10;
  localparam int STAT_BUSY  = 11;

  localparam int CTRL_ENABLE    = 0;
  localparam int CTRL_FLUSH     = 1;
  localparam int CTRL_IEN_EMPTY = 2;
  localparam int CTRL_IEN_THR   = 3;
  localparam int CTRL_ST_EMPTY  = 4;
  localparam int CTRL_ST_THR    = 5;
  localparam int CTRL_OVF       = 6;
  localparam int CTRL_THR_LSB   = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    POLL  = 3'd1,
    WPOLL = 3'd2,
    SEND  = 3'd3,
    WSEND = 3'd4,
    GAP   = 3'd5
  } fsm_state_t;

endpackage

// File: rtl/uart_tx_feeder_sfifo.sv
// Synchronous FIFO with occupancy count; flush clears pointers and count
// and takes priority over a push or pop in the same cycle.
module sfifo #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rstb,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] head,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0] mem [2**AW];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // count only reaches 2**AW when full, so its top bit is the full flag
  assign full    = count[AW];
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers CPU-written characters and drains them into uart_tx by polling
// its busy flag and writing its data register over the master port.
module uart_tx_feeder
  import uart_tx_feeder_pkg::*;
#(
  parameter int          AW      = 4,
  parameter int          DW      = 8,
  parameter logic [31:0] TX_BASE = 32'h0,
  parameter int          GUARD   = 4
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic        valid,
  input  logic        write,
  input  logic [31:0] addr,
  input  logic [1:0]  size,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        irq,
  output logic        m_valid,
  output logic        m_write,
  output logic [31:0] m_addr,
  output logic [1:0]  m_size,
  output logic [31:0] m_wdata,
  input  logic        m_ready,
  input  logic [31:0] m_rdata
);

  localparam int           GW         = (GUARD < 2) ? 1 : $clog2(GUARD + 1);
  localparam logic [GW-1:0] GUARD_INIT = GW'(GUARD);

  fsm_state_t    state, state_nx;
  logic          enable, irq_en_empty, irq_en_thr;
  logic          st_empty, st_thr, ovf;
  logic [7:0]    thr;
  logic          flush_pend;
  logic [GW-1:0] guard;
  logic [DW-1:0] head;
  logic [AW:0]   count;
  logic          full, empty;
  logic [31:0]   reg_addr;
  logic          wr_data, wr_ctrl;
  logic          push, pop, flush, load_guard;
  logic          set_empty, set_thr, set_ovf;
  logic [7:0]    count_after;
  logic [31:0]   rd_value;
  logic          unused_bits;

  assign reg_addr    = addr & ~32'h3;
  assign wr_data     = valid && write && (reg_addr == REG_DATA);
  assign wr_ctrl     = valid && write && (reg_addr == REG_CTRL);
  assign push        = wr_data && !full;
  assign flush       = wr_ctrl && wdata[CTRL_FLUSH];
  assign set_ovf     = wr_data && full;
  assign count_after = 8'(count) - 8'd1 + 8'(push);
  assign set_empty   = pop && (count == (AW+1)'(1)) && !push;
  assign set_thr     = pop && (count_after <= thr);
  assign irq         = (irq_en_empty && st_empty) || (irq_en_thr && st_thr);
  assign m_size      = 2'b10;
  assign unused_bits = ^{size, wdata[31:16], m_rdata};

  sfifo #(.AW(AW), .DW(DW)) fifo (
    .clk   (clk),
    .rstb  (rstb),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (wdata[DW-1:0]),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    rd_value = '0;
    case (reg_addr)
      REG_STAT: begin
        rd_value[AW:0]       = count;
        rd_value[STAT_EMPTY] = empty;
        rd_value[STAT_FULL]  = full;
        rd_value[STAT_OVF]   = ovf;
        rd_value[STAT_BUSY]  = (state != IDLE);
      end
      REG_CTRL: begin
        rd_value[CTRL_ENABLE]        = enable;
        rd_value[CTRL_IEN_EMPTY]     = irq_en_empty;
        rd_value[CTRL_IEN_THR]       = irq_en_thr;
        rd_value[CTRL_ST_EMPTY]      = st_empty;
        rd_value[CTRL_ST_THR]        = st_thr;
        rd_value[CTRL_OVF]           = ovf;
        rd_value[CTRL_THR_LSB +: 8]  = thr;
      end
      default: rd_value = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      ready <= 1'b0;
      rdata <= '0;
    end else begin
      ready <= valid;
      rdata <= (valid && !write) ? rd_value : '0;
    end
  end

  // Status flags: a hardware set in the same cycle as a write-1-clear wins
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      enable       <= 1'b0;
      irq_en_empty <= 1'b0;
      irq_en_thr   <= 1'b0;
      thr          <= '0;
      st_empty     <= 1'b0;
      st_thr       <= 1'b0;
      ovf          <= 1'b0;
      flush_pend   <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        enable       <= wdata[CTRL_ENABLE];
        irq_en_empty <= wdata[CTRL_IEN_EMPTY];
        irq_en_thr   <= wdata[CTRL_IEN_THR];
        thr          <= wdata[CTRL_THR_LSB +: 8];
      end
      if (set_empty)                             st_empty <= 1'b1;
      else if (wr_ctrl && wdata[CTRL_ST_EMPTY])  st_empty <= 1'b0;
      if (set_thr)                               st_thr <= 1'b1;
      else if (wr_ctrl && wdata[CTRL_ST_THR])    st_thr <= 1'b0;
      if (set_ovf)                               ovf <= 1'b1;
      else if (wr_ctrl && wdata[CTRL_OVF])       ovf <= 1'b0;
      if (flush)                                 flush_pend <= (state != IDLE);
      else if (state == IDLE)                    flush_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state <= IDLE;
      guard <= '0;
    end else begin
      state <= state_nx;
      if (load_guard)                      guard <= GUARD_INIT;
      else if (state == GAP && guard != '0) guard <= guard - 1'b1;
    end
  end

  // A flush seen while a transaction is open abandons the character: the
  // poll or send finishes on the bus, then the FSM settles through GAP
  always_comb begin
    state_nx   = state;
    load_guard = 1'b0;
    pop        = 1'b0;
    m_valid    = 1'b0;
    m_write    = 1'b0;
    m_addr     = '0;
    m_wdata    = '0;
    case (state)
      IDLE: begin
        if (enable && !empty && !flush) state_nx = POLL;
      end
      POLL: begin
        m_valid  = 1'b1;
        m_addr   = TX_BASE + TX_CTRL_OFS;
        state_nx = WPOLL;
      end
      WPOLL: begin
        if (m_ready) begin
          if (flush || flush_pend || !enable) begin
            load_guard = 1'b1;
            state_nx   = GAP;
          end else if (!m_rdata[TX_BUSY_BIT]) begin
            state_nx = SEND;
          end else begin
            state_nx = POLL;
          end
        end
      end
      SEND: begin
        m_valid  = 1'b1;
        m_write  = 1'b1;
        m_addr   = TX_BASE + TX_DATA_OFS;
        m_wdata  = {{(32-DW){1'b0}}, head};
        state_nx = WSEND;
      end
      WSEND: begin
        if (m_ready) begin
          pop        = !(flush || flush_pend);
          load_guard = 1'b1;
          state_nx   = GAP;
        end
      end
      GAP: begin
        if (guard == '0) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule
